// File: rtl/dsp_dot_acc_pkg.sv
// Shared width helper, signedness mode constants and lane packing macro for the
// dot-product accumulator.
`define DSP_LANE(vec, idx, w) vec[(idx)*(w) +: (w)]

package dsp_dot_acc_pkg;

  localparam int SIGN_UNSIGNED = 0;
  localparam int SIGN_TWOS     = 1;

  // Width of the lane sum: full product plus one growth bit per tree level.
  function automatic int sum_width(input int lanes, input int dwidth);
    return 2 * dwidth + ((lanes > 1) ? $clog2(lanes) : 0);
  endfunction

endpackage

// File: rtl/dsp_dot_acc_if.sv
// Beat input stream and result output stream of the dot-product accumulator.
// The master drives beats and out_ready; the slave (the datapath) returns the rest.
interface dsp_dot_acc_if #(
  parameter int LANES     = 2,
  parameter int DWIDTH    = 18,
  parameter int ACC_WIDTH = 48
);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DWIDTH-1:0] in_a;
  logic [LANES*DWIDTH-1:0] in_b;
  logic                    in_first;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    out_data;
  logic                    out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/dsp_dot_acc_adder_tree.sv
// Registered LANES-input adder tree: products are extended to the sum width and
// reduced pairwise; the result register only advances while en is high.
module dsp_dot_acc_adder_tree
  import dsp_dot_acc_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int IN_W   = 36,
  parameter int OUT_W  = 37,
  parameter int SIGNED = SIGN_UNSIGNED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [LANES*IN_W-1:0] terms,
  output logic [OUT_W-1:0]      sum
);

  localparam int LEAVES = (LANES > 1) ? (1 << $clog2(LANES)) : 1;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [OUT_W-1:0] node [NODES];

  // Heap layout: leaves occupy the top LEAVES slots, unused leaves stay zero.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      node[n] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED == SIGN_TWOS) begin
        node[LEAVES-1+i] = OUT_W'($signed(`DSP_LANE(terms, i, IN_W)));
      end else begin
        node[LEAVES-1+i] = OUT_W'(`DSP_LANE(terms, i, IN_W));
      end
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      node[n] = node[2*n+1] + node[2*n+2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (en) begin
      sum <= node[0];
    end
  end

endmodule

// File: rtl/dsp_dot_acc.sv
// N-lane multiply/sum/accumulate pipeline: S1 multiplies, S2 sums lanes, S3 accumulates
// over first/last framed beats and holds the result until the consumer takes it.
module dsp_dot_acc
  import dsp_dot_acc_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int DWIDTH    = 18,
  parameter int ACC_WIDTH = 48,
  parameter int SIGNED    = SIGN_UNSIGNED
) (
  input logic          clk,
  input logic          rst_n,
  dsp_dot_acc_if.slave bus
);

  localparam int PROD_W = 2 * DWIDTH;
  localparam int SUM_W  = sum_width(LANES, DWIDTH);
  localparam int MSB    = ACC_WIDTH - 1;

  if (LANES < 1 || LANES > 16) begin : g_lanes_check
    $error("dsp_dot_acc: LANES=%0d outside 1..16", LANES);
  end

  if (ACC_WIDTH < SUM_W) begin : g_width_check
    $error("dsp_dot_acc: ACC_WIDTH=%0d narrower than lane sum width %0d", ACC_WIDTH, SUM_W);
  end

  logic                    en;
  logic [PROD_W-1:0]       ext_a;
  logic [PROD_W-1:0]       ext_b;
  logic [LANES*PROD_W-1:0] prod_d;
  logic [LANES*PROD_W-1:0] s1_prod;
  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic                    s2_valid;
  logic                    s2_first;
  logic                    s2_last;
  logic [SUM_W-1:0]        s2_sum;
  logic [ACC_WIDTH-1:0]    sum_ext;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_base;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic [ACC_WIDTH-1:0]    out_data_q;
  logic                    carry;
  logic                    add_ovf;
  logic                    ovf;
  logic                    ovf_base;
  logic                    ovf_next;
  logic                    out_valid_q;
  logic                    out_ovf_q;

  // A single enable freezes the whole pipe while a result waits for the consumer.
  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

  // Operands are widened to the product width first so one modular multiply serves both modes.
  always_comb begin
    prod_d = '0;
    ext_a  = '0;
    ext_b  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (SIGNED == SIGN_TWOS) begin
        ext_a = {{DWIDTH{bus.in_a[i*DWIDTH+DWIDTH-1]}}, `DSP_LANE(bus.in_a, i, DWIDTH)};
        ext_b = {{DWIDTH{bus.in_b[i*DWIDTH+DWIDTH-1]}}, `DSP_LANE(bus.in_b, i, DWIDTH)};
      end else begin
        ext_a = {{DWIDTH{1'b0}}, `DSP_LANE(bus.in_a, i, DWIDTH)};
        ext_b = {{DWIDTH{1'b0}}, `DSP_LANE(bus.in_b, i, DWIDTH)};
      end
      `DSP_LANE(prod_d, i, PROD_W) = ext_a * ext_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_first <= bus.in_first;
      s1_last  <= bus.in_last;
      s1_prod  <= prod_d;
    end
  end

  dsp_dot_acc_adder_tree #(
    .LANES  (LANES),
    .IN_W   (PROD_W),
    .OUT_W  (SUM_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .terms (s1_prod),
    .sum   (s2_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // Unsigned frames flag a carry out; signed frames flag a same-sign add that flips sign.
  always_comb begin
    if (SIGNED == SIGN_TWOS) begin
      sum_ext = ACC_WIDTH'($signed(s2_sum));
    end else begin
      sum_ext = ACC_WIDTH'(s2_sum);
    end
    acc_base            = s2_first ? '0 : acc;
    ovf_base            = s2_first ? 1'b0 : ovf;
    {carry, acc_next}   = {1'b0, acc_base} + {1'b0, sum_ext};
    add_ovf             = carry;
    if (SIGNED == SIGN_TWOS) begin
      add_ovf = (acc_base[MSB] == sum_ext[MSB]) && (acc_next[MSB] != acc_base[MSB]);
    end
    ovf_next = ovf_base | add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (en) begin
      if (s2_valid) begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
      out_valid_q <= s2_valid && s2_last;
      if (s2_valid && s2_last) begin
        out_data_q <= acc_next;
        out_ovf_q  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_dsp_dot_acc.sv
// Bench for dsp_dot_acc: unsigned and signed instances share one stimulus stream and a
// queue scoreboard checks every accepted result against a plain-integer model.
module tb_dsp_dot_acc;

  localparam int LANES       = 2;
  localparam int DW          = 18;
  localparam int ACCW        = 37;
  localparam int CYCLE_LIMIT = 400;

  typedef struct packed {
    logic [ACCW-1:0] data;
    logic            ovf;
  } exp_t;

  logic                clk        = 1'b0;
  logic                rst_n      = 1'b0;
  logic                tbValid    = 1'b0;
  logic                tbFirst    = 1'b0;
  logic                tbLast     = 1'b0;
  logic                tbOutReady = 1'b1;
  logic [LANES*DW-1:0] tbA        = '0;
  logic [LANES*DW-1:0] tbB        = '0;
  int                  readyMode  = 0;
  int                  testsRun   = 0;
  int                  testsFailed = 0;
  exp_t                expQU[$];
  exp_t                expQS[$];
  longint              macc[2];
  bit                  movf[2];

  always #5 clk = ~clk;

  dsp_dot_acc_if #(.LANES(LANES), .DWIDTH(DW), .ACC_WIDTH(ACCW)) ifU ();
  dsp_dot_acc_if #(.LANES(LANES), .DWIDTH(DW), .ACC_WIDTH(ACCW)) ifS ();

  assign ifU.in_valid  = tbValid;
  assign ifU.in_a      = tbA;
  assign ifU.in_b      = tbB;
  assign ifU.in_first  = tbFirst;
  assign ifU.in_last   = tbLast;
  assign ifU.out_ready = tbOutReady;
  assign ifS.in_valid  = tbValid;
  assign ifS.in_a      = tbA;
  assign ifS.in_b      = tbB;
  assign ifS.in_first  = tbFirst;
  assign ifS.in_last   = tbLast;
  assign ifS.out_ready = tbOutReady;

  dsp_dot_acc #(.LANES(LANES), .DWIDTH(DW), .ACC_WIDTH(ACCW), .SIGNED(0)) u_dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifU)
  );

  dsp_dot_acc #(.LANES(LANES), .DWIDTH(DW), .ACC_WIDTH(ACCW), .SIGNED(1)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifS)
  );

  // Consumer readiness: 0 always ready, 1 stalled, otherwise random.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       tbOutReady = 1'b1;
      1:       tbOutReady = 1'b0;
      default: tbOutReady = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [LANES*DW-1:0] pack2(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    return {l1, l0};
  endfunction

  function automatic logic [DW-1:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return DW'($urandom_range(0, 15));
      1:       return 18'h3FFFF;
      2:       return 18'h20000;
      default: return DW'($urandom());
    endcase
  endfunction

  function automatic longint laneVal(input logic [DW-1:0] v, input int sgn);
    if (sgn != 0) return longint'($signed(v));
    return longint'(v);
  endfunction

  // Exact integer arithmetic per mode; overflow is "the true sum left the representable range".
  task automatic modelBeat(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                           input logic f, input logic l);
    longint lim;
    longint half;
    longint dot;
    longint t;
    bit     o;
    exp_t   e;
    lim  = longint'(1) << ACCW;
    half = lim >> 1;
    for (int s = 0; s < 2; s++) begin
      dot = 0;
      for (int i = 0; i < LANES; i++) begin
        dot += laneVal(a[i*DW +: DW], s) * laneVal(b[i*DW +: DW], s);
      end
      t = (f ? 64'sd0 : macc[s]) + dot;
      o = f ? 1'b0 : movf[s];
      if (s == 0) begin
        if (t >= lim) o = 1'b1;
        t = t % lim;
      end else begin
        if (t >= half || t < -half) o = 1'b1;
        t = t & (lim - 1);
        if (t >= half) t = t - lim;
      end
      macc[s] = t;
      movf[s] = o;
      if (l) begin
        e.data = t[ACCW-1:0];
        e.ovf  = o;
        if (s == 0) expQU.push_back(e);
        else expQS.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                               input logic f, input logic l);
    int waitCycles;
    bit accepted;
    tbA = a;
    tbB = b;
    tbFirst = f;
    tbLast = l;
    tbValid = 1'b1;
    accepted = 1'b0;
    waitCycles = 0;
    while (!accepted && waitCycles < CYCLE_LIMIT) begin
      @(negedge clk);
      if (ifU.in_ready === 1'b1) accepted = 1'b1;
      else waitCycles++;
    end
    if (accepted) begin
      @(posedge clk);
      modelBeat(a, b, f, l);
    end else begin
      checkOutput("in_ready wait", 64'(ifU.in_ready), 64'd1);
    end
    #1;
    tbValid = 1'b0;
  endtask

  task automatic checkResult(input int s, input logic [ACCW-1:0] d, input logic o);
    exp_t e;
    if ((s == 0 && expQU.size() == 0) || (s == 1 && expQS.size() == 0)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL result inst%0d unexpected: got data=%0h, required no result", s, d);
      return;
    end
    if (s == 0) e = expQU.pop_front();
    else e = expQS.pop_front();
    checkOutput(s == 0 ? "U out_data" : "S out_data", 64'(d), 64'(e.data));
    checkOutput(s == 0 ? "U out_ovf" : "S out_ovf", 64'(o), 64'(e.ovf));
  endtask

  // Monitor: a result counts when out_valid and out_ready are both high before the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifU.out_valid && tbOutReady) checkResult(0, ifU.out_data, ifU.out_ovf);
      if (ifS.out_valid && tbOutReady) checkResult(1, ifS.out_data, ifS.out_ovf);
    end
  end

  task automatic waitDrain();
    int n;
    readyMode = 0;
    n = 0;
    while ((expQU.size() != 0 || expQS.size() != 0) && n < CYCLE_LIMIT) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain U pending", 64'(expQU.size()), 64'd0);
    checkOutput("drain S pending", 64'(expQS.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    macc[0] = 0;
    macc[1] = 0;
    movf[0] = 1'b0;
    movf[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid U", 64'(ifU.out_valid), 64'd0);
    checkOutput("reset out_data U", 64'(ifU.out_data), 64'd0);
    checkOutput("reset out_ovf U", 64'(ifU.out_ovf), 64'd0);
    checkOutput("reset out_valid S", 64'(ifS.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset in_ready", 64'(ifU.in_ready), 64'd1);

    // Single-beat frame and its latency.
    applyStimulus(pack2(18'd3, 18'd4), pack2(18'd3, 18'd4), 1'b1, 1'b1);
    checkOutput("latency edge k", 64'(ifU.out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency edge k+1", 64'(ifU.out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency edge k+2", 64'(ifU.out_valid), 64'd1);
    waitDrain();

    // Three-beat frame gives one result, valid for exactly one cycle.
    applyStimulus(pack2(18'd1, 18'd1), pack2(18'd1, 18'd1), 1'b1, 1'b0);
    applyStimulus(pack2(18'd2, 18'd2), pack2(18'd2, 18'd2), 1'b0, 1'b0);
    applyStimulus(pack2(18'd3, 18'd3), pack2(18'd3, 18'd3), 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("frame out_valid k+1", 64'(ifU.out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("frame out_valid k+2", 64'(ifU.out_valid), 64'd1);
    @(posedge clk); #1;
    checkOutput("frame out_valid k+3", 64'(ifU.out_valid), 64'd0);
    waitDrain();

    // Negative operands: (-2*7) + (5*-1).
    applyStimulus(pack2(18'h3FFFE, 18'd5), pack2(18'd7, 18'h3FFFF), 1'b1, 1'b1);
    waitDrain();

    // Unsigned wrap, signed wrap, each followed by a fresh frame clearing the flag.
    applyStimulus(pack2(18'h3FFFF, 18'h3FFFF), pack2(18'h3FFFF, 18'h3FFFF), 1'b1, 1'b0);
    applyStimulus(pack2(18'h3FFFF, 18'h3FFFF), pack2(18'h3FFFF, 18'h3FFFF), 1'b0, 1'b1);
    applyStimulus(pack2(18'd1, 18'd0), pack2(18'd1, 18'd0), 1'b1, 1'b1);
    applyStimulus(pack2(18'h20000, 18'h20000), pack2(18'h20000, 18'h20000), 1'b1, 1'b0);
    applyStimulus(pack2(18'h20000, 18'h20000), pack2(18'h20000, 18'h20000), 1'b0, 1'b1);
    applyStimulus(pack2(18'd2, 18'd0), pack2(18'd2, 18'd0), 1'b1, 1'b1);
    waitDrain();

    // Stall with a full pipe: three results queue up behind a blocked consumer.
    readyMode = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(pack2(randOperand(), randOperand()), pack2(randOperand(), randOperand()), 1'b1, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", 64'(ifU.in_ready), 64'd0);
      checkOutput("stall out_valid", 64'(ifU.out_valid), 64'd1);
      if (expQU.size() != 0) checkOutput("stall out_data held", 64'(ifU.out_data), 64'(expQU[0].data));
    end
    waitDrain();

    // Random frames under random backpressure.
    readyMode = 2;
    for (int fr = 0; fr < 40; fr++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        applyStimulus(pack2(randOperand(), randOperand()), pack2(randOperand(), randOperand()),
                      (j == 0), (j == len - 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    waitDrain();

    // Reset in the middle of a frame discards the partial accumulation.
    applyStimulus(pack2(18'd5, 18'd6), pack2(18'd7, 18'd8), 1'b1, 1'b1);
    waitDrain();
    applyStimulus(pack2(18'd9, 18'd9), pack2(18'd9, 18'd9), 1'b1, 1'b0);
    applyStimulus(pack2(18'd2, 18'd3), pack2(18'd4, 18'd5), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid U", 64'(ifU.out_valid), 64'd0);
    checkOutput("midreset out_data U", 64'(ifU.out_data), 64'd0);
    checkOutput("midreset out_ovf U", 64'(ifU.out_ovf), 64'd0);
    checkOutput("midreset out_data S", 64'(ifS.out_data), 64'd0);
    expQU.delete();
    expQS.delete();
    macc[0] = 0;
    macc[1] = 0;
    movf[0] = 1'b0;
    movf[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset in_ready", 64'(ifU.in_ready), 64'd1);
    applyStimulus(pack2(18'd1, 18'd0), pack2(18'd1, 18'd0), 1'b1, 1'b1);
    applyStimulus(pack2(18'd2, 18'd0), pack2(18'd3, 18'd0), 1'b0, 1'b1);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
